// File: rtl/colour_map_filter_pkg.sv
// Shared types and the per-channel colour map for colour_map_filter.
// Widths are bounded by the MAX_* limits so one package serves every instance.
package colour_map_pkg;

    localparam int unsigned MAX_CH_W    = 32;
    localparam int unsigned MAX_LEVEL_W = 8;
    localparam int unsigned MAX_NUM_CH  = 16;

    typedef enum logic [1:0] {
        PASS      = 2'd0,
        INVERT    = 2'd1,
        POSTERIZE = 2'd2,
        THRESHOLD = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    typedef struct packed {
        mode_e                  mode;
        logic [MAX_LEVEL_W-1:0] level;
        logic [MAX_NUM_CH-1:0]  mask;
        logic                   use_en;
    } cfg_t;

    function automatic logic [MAX_CH_W-1:0] map_channel(
        input mode_e                  m,
        input logic [MAX_LEVEL_W-1:0] lvl,
        input logic [MAX_CH_W-1:0]    c,
        input int unsigned            ch_w,
        input int unsigned            level_w
    );
        logic [MAX_CH_W-1:0] ones;
        logic [MAX_CH_W-1:0] low;
        logic [MAX_CH_W-1:0] thr;
        logic [MAX_CH_W-1:0] r;
        int unsigned         l;
        int unsigned         n;
        ones = '1;
        ones = ones >> (MAX_CH_W - ch_w);
        l    = 32'(lvl);
        n    = (l > ch_w) ? ch_w : l;
        low  = (n == 0) ? '0 : (ones >> (ch_w - n));
        // Threshold scales the level into the top LEVEL_W bits of the channel.
        thr  = (l << (ch_w - level_w)) & ones;
        case (m)
            INVERT:    r = (l != 0) ? (~c & ones) : c;
            POSTERIZE: r = c & ones & ~low;
            THRESHOLD: r = (l == 0) ? c : ((c >= thr) ? ones : '0);
            default:   r = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/colour_map_filter_skid.sv
// Registered output stage with a one-beat skid; ready_o is a flop (!skid_full),
// never a combinational path from m_ready_i.
module stream_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid_i,
    input  logic [W-1:0] s_data_i,
    output logic         s_ready_o,
    output logic         m_valid_o,
    output logic [W-1:0] m_data_o,
    input  logic         m_ready_i
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         ready_q;
    logic         in_fire;

    assign in_fire = s_valid_i && ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || m_ready_i) begin
            // Output slot frees up: the skid beat is older, so it goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) out_data_d = s_data_i;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_data_q;

endmodule

// File: rtl/colour_map_filter.sv
// Per-pixel colour map over a valid/ready/sop/eop stream; configuration is
// latched at start-of-packet so a frame is always mapped with one setting.
module colour_map_filter
    import colour_map_pkg::*;
#(
    parameter int unsigned CH_W    = 4,
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned LEVEL_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LEVEL_W-1:0]     freq_flag,
    input  logic                   use_flag,
    input  logic [1:0]             mode,
    input  logic [NUM_CH-1:0]      ch_mask,
    input  logic [CH_W*NUM_CH-1:0] data_in,
    input  logic                   sop_in,
    input  logic                   eop_in,
    input  logic                   valid_in,
    input  logic                   ready_in,
    output logic                   ready_out,
    output logic [CH_W*NUM_CH-1:0] data_out,
    output logic                   sop_out,
    output logic                   eop_out,
    output logic                   valid_out
);

    localparam int unsigned DW = CH_W * NUM_CH;
    localparam int unsigned PW = DW + 2;

    cfg_t                cfg_q, cfg_d, live_cfg, eff_cfg;
    state_e              state_q, state_d;
    logic                accept;
    logic                fwd;
    logic [DW-1:0]       mapped;
    logic [MAX_CH_W-1:0] chan;
    logic                unused_bits;

    always_comb begin
        live_cfg        = '0;
        live_cfg.mode   = mode_e'(mode);
        live_cfg.level  = MAX_LEVEL_W'(freq_flag);
        live_cfg.mask   = MAX_NUM_CH'(ch_mask);
        live_cfg.use_en = use_flag;
    end

    // The sop pixel is mapped with the live inputs it is about to latch.
    assign eff_cfg = sop_in ? live_cfg : cfg_q;
    assign accept  = valid_in && ready_out;
    assign fwd     = sop_in || (state_q == ACTIVE);

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        if (accept) begin
            if (sop_in) begin
                cfg_d   = live_cfg;
                state_d = eop_in ? IDLE : ACTIVE;
            end else if (state_q == ACTIVE && eop_in) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cfg_q   <= '{mode: PASS, level: '0, mask: '1, use_en: 1'b1};
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
        end
    end

    always_comb begin
        mapped = '0;
        chan   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            chan = map_channel(eff_cfg.mode, eff_cfg.level,
                               MAX_CH_W'(data_in[i*CH_W +: CH_W]), CH_W, LEVEL_W);
            mapped[i*CH_W +: CH_W] = eff_cfg.mask[i] ? chan[CH_W-1:0]
                                                     : data_in[i*CH_W +: CH_W];
        end
        if (!eff_cfg.use_en) mapped = '0;
    end

    assign unused_bits = ^{eff_cfg.mask, chan};

    stream_skid_buffer #(
        .W(PW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .s_valid_i (valid_in && fwd),
        .s_data_i  ({sop_in, eop_in, mapped}),
        .s_ready_o (ready_out),
        .m_valid_o (valid_out),
        .m_data_o  ({sop_out, eop_out, data_out}),
        .m_ready_i (ready_in)
    );

endmodule

// File: tb/tb_colour_map_filter.sv
// Scoreboard bench for colour_map_filter: expected beats are queued at accept
// and compared when the output handshake completes.
module tb_colour_map_filter;

    localparam int unsigned CH_W = 4, NUM_CH = 3, LEVEL_W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  freq_flag = '0;
    logic        use_flag = 1'b1;
    logic [1:0]  mode = '0;
    logic [2:0]  ch_mask = 3'b111;
    logic [11:0] data_in = '0;
    logic        sop_in = 1'b0, eop_in = 1'b0, valid_in = 1'b0;
    logic        ready_in;
    logic        ready_out;
    logic [11:0] data_out;
    logic        sop_out, eop_out, valid_out;

    always #5 clk = ~clk;

    colour_map_filter #(.CH_W(CH_W), .NUM_CH(NUM_CH), .LEVEL_W(LEVEL_W)) dut (
        .clk(clk), .reset(reset), .freq_flag(freq_flag), .use_flag(use_flag),
        .mode(mode), .ch_mask(ch_mask), .data_in(data_in), .sop_in(sop_in),
        .eop_in(eop_in), .valid_in(valid_in), .ready_in(ready_in),
        .ready_out(ready_out), .data_out(data_out), .sop_out(sop_out),
        .eop_out(eop_out), .valid_out(valid_out)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [13:0] exp_q[$];
    int unsigned rdy_mode = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic [11:0] d, input logic [1:0] m,
                                          input int unsigned l, input logic [2:0] msk,
                                          input logic u);
        logic [11:0] r;
        logic [3:0]  c, o;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            c = d[k*4 +: 4];
            case (m)
                2'd1:    o = (l > 0) ? 4'hF - c : c;
                2'd2:    o = (l >= 4) ? 4'h0 : ((c >> l) << l);
                2'd3:    o = (l == 0) ? c : ((c >= l * 4) ? 4'hF : 4'h0);
                default: o = c;
            endcase
            r[k*4 +: 4] = msk[k] ? o : c;
        end
        return u ? r : 12'h000;
    endfunction

    // ready_in: 0 = always ready, 1 = random 75% with 3-clk stall bursts, 2 = stalled
    initial begin
        int unsigned stall_left;
        stall_left = 0;
        ready_in = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: ready_in = 1'b1;
                1: begin
                    if (stall_left != 0) begin
                        ready_in = 1'b0;
                        stall_left--;
                    end else if ($urandom_range(15) == 0) begin
                        ready_in = 1'b0;
                        stall_left = 2;
                    end else begin
                        ready_in = ($urandom_range(3) != 0);
                    end
                end
                default: ready_in = 1'b0;
            endcase
        end
    end

    logic        prev_stall = 1'b0, prev_ready = 1'b0, prev_rst = 1'b0;
    logic [14:0] prev_out = '0;
    logic [13:0] exp_beat;

    always @(negedge clk) begin
        if (reset && prev_rst) begin
            if (prev_stall)
                chk("hold_while_stalled", {valid_out, sop_out, eop_out, data_out}, prev_out);
            if (prev_ready && !ready_out)
                chk("ready_drop_only_on_stall", prev_stall, 1);
        end
        if (reset && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat_queue_size", exp_q.size(), 1);
            end else begin
                exp_beat = exp_q.pop_front();
                chk("beat", {sop_out, eop_out, data_out}, exp_beat);
            end
        end
        prev_stall = valid_out && !ready_in;
        prev_out   = {valid_out, sop_out, eop_out, data_out};
        prev_ready = ready_out;
        prev_rst   = reset;
    end

    task automatic drive(input logic [11:0] d, input logic s, input logic e,
                         input logic fwd, input logic [11:0] exp);
        logic        acc;
        int unsigned waits;
        acc = 1'b0;
        waits = 0;
        data_in = d; sop_in = s; eop_in = e; valid_in = 1'b1;
        do begin
            @(negedge clk); acc = ready_out;
            @(posedge clk); #1;
            waits++;
        end while (!acc && waits < 200);
        valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
        if (!acc) chk("accept_timeout", waits, 0);
        else if (fwd) exp_q.push_back({s, e, exp});
    endtask

    task automatic frame(input int unsigned n, input logic [11:0] d, input logic [11:0] exp);
        for (int unsigned p = 0; p < n; p++)
            drive(d, p == 0, p == n - 1, 1'b1, exp);
    endtask

    task automatic drain();
        int unsigned w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [11:0] d;
        logic [1:0]  lm;
        int unsigned ll, len;
        logic [2:0]  lk;
        logic        lu;

        // 1: reset and PASS with 1-clk latency
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready_out", ready_out, 0);
        chk("reset_valid_out", valid_out, 0);
        chk("reset_data_out", data_out, 0);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ready_after_release", ready_out, 1);
        @(posedge clk); #1;
        mode = 2'd0;
        drive(12'h18F, 1'b1, 1'b0, 1'b1, 12'h18F);
        chk("latency_1clk", {valid_out, sop_out, data_out}, {1'b1, 1'b1, 12'h18F});
        for (int p = 0; p < 3; p++) drive(12'h18F, 1'b0, p == 2, 1'b1, 12'h18F);
        drain();

        // 2-3: map modes, channel mask, use_flag
        mode = 2'd1; freq_flag = 2'd2; frame(3, 12'h18F, 12'hE70);
        freq_flag = 2'd0;              frame(2, 12'h18F, 12'h18F);
        mode = 2'd2; freq_flag = 2'd2; frame(2, 12'h18F, 12'h08C);
        mode = 2'd3;                   frame(2, 12'h18F, 12'h0FF);
        mode = 2'd1; ch_mask = 3'b001; frame(2, 12'h18F, 12'h180);
        ch_mask = 3'b111; use_flag = 1'b0; frame(3, 12'h18F, 12'h000);
        use_flag = 1'b1;
        drain();

        // 4: mid-frame config change is ignored until the next sop
        mode = 2'd1; freq_flag = 2'd2;
        drive(12'h18F, 1'b1, 1'b0, 1'b1, 12'hE70);
        mode = 2'd0;
        drive(12'h18F, 1'b0, 1'b0, 1'b1, 12'hE70);
        drive(12'h18F, 1'b0, 1'b1, 1'b1, 12'hE70);
        frame(2, 12'h18F, 12'h18F);
        drain();

        // 5: random backpressure against the model
        rdy_mode = 1;
        for (int f = 0; f < 16; f++) begin
            len = $urandom_range(1, 6);
            mode = 2'($urandom_range(3)); freq_flag = 2'($urandom_range(3));
            ch_mask = 3'($urandom_range(7)); use_flag = ($urandom_range(7) != 0);
            lm = mode; ll = freq_flag; lk = ch_mask; lu = use_flag;
            for (int unsigned p = 0; p < len; p++) begin
                d = 12'($urandom_range(4095));
                if (p > 0) begin
                    mode = 2'($urandom_range(3)); freq_flag = 2'($urandom_range(3));
                    ch_mask = 3'($urandom_range(7)); use_flag = ($urandom_range(1) != 0);
                end
                drive(d, p == 0, p == len - 1, 1'b1, model(d, lm, ll, lk, lu));
            end
        end
        rdy_mode = 0;
        drain();

        // 6: resync, missing eop, single-beat frame, mid-frame reset
        mode = 2'd0; ch_mask = 3'b111; use_flag = 1'b1; freq_flag = 2'd0;
        drive(12'h123, 1'b0, 1'b0, 1'b0, 12'h000);
        drive(12'h456, 1'b0, 1'b1, 1'b0, 12'h000);
        mode = 2'd1; freq_flag = 2'd1;
        drive(12'h18F, 1'b1, 1'b0, 1'b1, 12'hE70);
        mode = 2'd2; freq_flag = 2'd2;
        drive(12'h18F, 1'b1, 1'b0, 1'b1, 12'h08C);
        mode = 2'd0;
        drive(12'h18F, 1'b0, 1'b1, 1'b1, 12'h08C);
        mode = 2'd3; freq_flag = 2'd2;
        drive(12'h18F, 1'b1, 1'b1, 1'b1, 12'h0FF);
        drive(12'h777, 1'b0, 1'b0, 1'b0, 12'h000);
        drain();

        mode = 2'd0;
        rdy_mode = 2;
        @(posedge clk); #1;
        drive(12'h18F, 1'b1, 1'b0, 1'b1, 12'h18F);
        drive(12'h18F, 1'b0, 1'b0, 1'b1, 12'h18F);
        @(negedge clk);
        chk("skid_full_ready_low", ready_out, 0);
        chk("stalled_valid_held", {valid_out, data_out}, {1'b1, 12'h18F});
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;
        chk("midframe_reset_valid", valid_out, 0);
        chk("midframe_reset_ready", ready_out, 0);
        exp_q.delete();
        rdy_mode = 0;
        @(posedge clk); #1; reset = 1'b1;
        drive(12'h321, 1'b0, 1'b1, 1'b0, 12'h000);
        frame(2, 12'h18F, 12'h18F);
        drain();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/colour_map_filter.md
Name: colour_map_filter

Overview:
Parametrised successor to the single-mode inversion filter in the video streaming chain.
- Applies one of four per-pixel colour maps (pass, invert, posterize, threshold) to selected channels of an N-channel pixel stream.
- Configuration is latched only at start-of-packet, so mode changes never tear a frame.
- Sits between the camera/scale stage and the VGA sink, using the same valid/ready/sop/eop stream protocol on both sides, with a registered output and a skid buffer.

Parameters:
- CH_W, 4, bits per colour channel
- NUM_CH, 3, number of channels; channel i occupies data[i*CH_W +: CH_W], so channel NUM_CH-1 (red) is in the MSBs
- LEVEL_W, 2, width of freq_flag strength level

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
- freq_flag  in  LEVEL_W  filter strength level; 0 = no effect
- use_flag  in  1  0 = output data forced to zero; framing and handshake unaffected
- mode  in  2  0 PASS, 1 INVERT, 2 POSTERIZE, 3 THRESHOLD
- ch_mask  in  NUM_CH  bit i set = map applied to channel i; clear = channel passed unchanged
- data_in  in  CH_W*NUM_CH  upstream pixel
- sop_in, eop_in, valid_in  in  1 each  upstream framing and valid
- ready_in  in  1  downstream ready
- ready_out  out  1  ready to upstream
- data_out  out  CH_W*NUM_CH  filtered pixel
- sop_out, eop_out, valid_out  out  1 each  downstream framing and valid

Behaviour:
- Reset (reset==0 at clk edge): valid_out=0, sop_out=0, eop_out=0, data_out=0, skid buffer empty, FSM=IDLE.
  - Latched config resets to mode=PASS, level=0, ch_mask=all ones, use=1.
  - ready_out=0 while reset is asserted; ready_out=1 the first cycle after release.
  - Reset mid-frame discards the in-flight pixel and the skid contents.
- Handshake: an upstream beat is accepted when valid_in && ready_out.
  - ready_out = !skid_full (registered, not combinational from ready_in).
  - Output advances when valid_out && ready_in. While ready_in=0, data_out/sop_out/eop_out/valid_out hold stable.
  - Latency: 1 clk from accept to valid_out when downstream is ready.
  - Throughput: 1 pixel/clk.
  - Skid buffer holds one beat. If the output register is stalled and a beat is accepted, that beat goes to the skid and ready_out drops the next cycle.
- Config latch:
  - On an accepted beat with sop_in=1, capture {mode, freq_flag, ch_mask, use_flag}.
  - The sop pixel itself uses the live inputs.
  - All other pixels use the latched copy. Input changes mid-frame have no effect until the next sop.
- FSM:
  - IDLE: accepted beats without sop are dropped (no output beat) to resync. An accepted sop moves to ACTIVE.
  - ACTIVE: pixels are mapped and forwarded. An accepted eop returns to IDLE. An accepted sop while ACTIVE (missing eop) re-latches config and stays ACTIVE; that beat is forwarded with sop_out=1.
  - A beat with sop_in && eop_in is a single-pixel frame: latch config, forward with both flags, stay IDLE.
- Per-channel map, for channel value c with lvl = level:
  - PASS: c.
  - INVERT: ~c if lvl>=1, else c.
  - POSTERIZE: c with the lvl LSBs cleared; lvl is saturated to CH_W.
  - THRESHOLD: if lvl==0, c; else (c >= lvl<<(CH_W-LEVEL_W)) ? all ones : 0. The threshold is computed at CH_W bits; no overflow for lvl < 2^LEVEL_W.
  - Map is applied only where ch_mask[i]=1.
  - If the effective use is 0, the whole pixel is 0.
- sop/eop/valid pass unchanged alongside the data; mapping is purely combinational into the output/skid registers.

Decomposition:
- Package colour_map_pkg:
  - mode_e enum (PASS, INVERT, POSTERIZE, THRESHOLD)
  - state_e enum (IDLE, ACTIVE)
  - cfg_t struct {mode, level, mask, use}
  - function map_channel()
- One sub-module: stream_skid_buffer, parametrised by payload width (data + sop + eop); it owns ready_out and the output register.

Test Plan:
Defaults CH_W=4, NUM_CH=3, ch_mask=3'b111, ready_in=1 unless stated.
1. Reset held 2 clks, then release; frame sop, 4 pixels 12'h18F, eop; mode=PASS -> ready_out=0 during reset, 1 after; data_out=12'h18F for each pixel, 1-clk latency.
2. mode=INVERT, freq_flag=2, data 12'h18F -> 12'hE70; same with freq_flag=0 -> 12'h18F.
3. POSTERIZE freq_flag=2 -> 12'h08C; THRESHOLD freq_flag=2 -> 12'h0FF; INVERT with ch_mask=3'b001 -> 12'h180; use_flag=0 at sop -> 12'h000 with sop/eop/valid intact.
4. Mode change INVERT->PASS mid-frame -> remaining pixels still inverted (12'hE70); next sop pixel -> 12'h18F.
5. ready_in randomised 75% plus 3-clk stall bursts -> no lost or duplicated beats; output sequence equals the scoreboard; outputs stable while stalled; ready_out drops only when the skid is full.
6. Pixels before the first sop dropped; sop without preceding eop re-latches config; single-beat sop+eop frame forwarded with both flags; reset asserted mid-frame -> valid_out=0 next clk, FSM=IDLE.
